toggle_cover_sched: RTL and testbench

Toggle-coverage scheduler for one WIDTH-bit monitored signal. It detects rising and falling transitions per bit and records first occurrences in a covered bitmap. Newly covered points are funnelled, one index per handshake, onto a single shared report channel that feeds the coverage DPI sink. It sits between the design signal being monitored and the coverage reporting back-end, replacing per-bit reporting with an arbitrated stream.

---
 rtl/toggle_cover_pkg.sv | 16 +
 rtl/rr_pick.sv | 25 ++
 rtl/toggle_cover_sched.sv | 117 +++++++++++
 tb/tb_toggle_cover_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage scheduler.
// Cover points are interleaved per bit: even = rise, odd = fall.
package toggle_cover_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEFAULT_IDX_W = 64;

  function automatic int cover_point(input int bit_idx, input logic is_fall);
    return 2 * bit_idx + (is_fall ? 1 : 0);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: lowest requesting index at or above the
// pointer, wrapping around to index 0.
module rr_pick #(
  parameter int N  = 32,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] grant_o,
  output logic          any_o
);

  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = |req_i;
    // Walk offsets from farthest to nearest so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) grant_o = PW'(idx);
    end
  end

endmodule

// File: rtl/toggle_cover_sched.sv
// Toggle-coverage scheduler: records first rise/fall of each monitored bit and
// streams newly covered point indices over a single valid/ready channel.
module toggle_cover_sched
  import toggle_cover_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               IDX_W       = DEFAULT_IDX_W,
  parameter logic [IDX_W-1:0] COVER_INDEX = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic [WIDTH-1:0]               sample_i,
  input  logic                           clear_i,
  output logic                           rpt_valid_o,
  input  logic                           rpt_ready_i,
  output logic [IDX_W-1:0]               rpt_index_o,
  output logic [2*WIDTH-1:0]             covered_o,
  output logic [$clog2(2*WIDTH+1)-1:0]   pending_cnt_o,
  output logic                           all_covered_o
);

  localparam int NP = 2 * WIDTH;
  localparam int PW = $clog2(NP);
  localparam int CW = $clog2(NP + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [NP-1:0]     covered_q, covered_d;
  logic [NP-1:0]     pending_q, pending_d;
  logic [PW-1:0]     sel_q, sel_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [NP-1:0]     ev_w, new_w, sel_oh, keep_w, cov_base, pend_base, pick_req;
  logic [PW-1:0]     next_ptr, pick_ptr, grant;
  logic              pick_any, hs, sampling;

  assign sampling = enable_i && prev_valid_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign ev_w[cover_point(gi, 1'b0)] = sampling && !prev_q[gi] &&  sample_i[gi];
    assign ev_w[cover_point(gi, 1'b1)] = sampling &&  prev_q[gi] && !sample_i[gi];
  end

  assign hs       = (state_q == HOLD) && rpt_ready_i;
  assign sel_oh   = NP'(1) << sel_q;
  assign next_ptr = (sel_q == PW'(NP - 1)) ? '0 : sel_q + PW'(1);

  // The in-flight point survives a clear so the open handshake completes.
  assign keep_w    = (state_q == HOLD) ? sel_oh : '0;
  assign cov_base  = clear_i ? (covered_q & keep_w) : covered_q;
  assign pend_base = clear_i ? (pending_q & keep_w) : pending_q;
  assign new_w     = ev_w & ~cov_base;

  assign covered_d    = cov_base | new_w;
  assign pending_d    = (pend_base | new_w) & ~(hs ? sel_oh : '0);
  assign prev_d       = enable_i ? sample_i : prev_q;
  assign prev_valid_d = enable_i;

  assign pick_req = (state_q == HOLD) ? (pend_base & ~sel_oh) : pend_base;
  assign pick_ptr = (state_q == HOLD) ? next_ptr : rr_q;

  rr_pick #(.N(NP), .PW(PW)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .grant_o (grant),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      covered_q    <= '0;
      pending_q    <= '0;
      sel_q        <= '0;
      rr_q         <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      covered_q    <= covered_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = HOLD;
      HOLD:    if (hs) state_d = pick_any ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic load;
    load  = pick_any && ((state_q == IDLE) || hs);
    sel_d = load ? grant : sel_q;
    idx_d = load ? (COVER_INDEX + IDX_W'(grant)) : idx_q;
    rr_d  = hs ? next_ptr : rr_q;

    rpt_valid_o   = (state_q == HOLD);
    rpt_index_o   = idx_q;
    covered_o     = covered_q;
    pending_cnt_o = CW'($countones(pending_q));
    all_covered_o = &covered_q;
  end

endmodule

// File: tb/tb_toggle_cover_sched.sv
// Directed bench for toggle_cover_sched (WIDTH=16, COVER_INDEX=100).
module tb_toggle_cover_sched;

  localparam int WIDTH = 16;
  localparam int IDX_W = 64;
  localparam logic [63:0] CI = 64'd100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [WIDTH-1:0]  sample;
  logic              clear;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [IDX_W-1:0]  rpt_index;
  logic [31:0]       covered;
  logic [5:0]        pending_cnt;
  logic              all_covered;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  toggle_cover_sched #(
    .WIDTH       (WIDTH),
    .IDX_W       (IDX_W),
    .COVER_INDEX (CI)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .sample_i      (sample),
    .clear_i       (clear),
    .rpt_valid_o   (rpt_valid),
    .rpt_ready_i   (rpt_ready),
    .rpt_index_o   (rpt_index),
    .covered_o     (covered),
    .pending_cnt_o (pending_cnt),
    .all_covered_o (all_covered)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      if (rpt_valid && rpt_ready) begin
        got_q.push_back(rpt_index);
        $display("report index=%0d pending_cnt=%0d", rpt_index, pending_cnt);
      end
      step();
    end
  endtask

  task automatic check_reports(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; sample = '0; clear = 1'b0; rpt_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    do_reset();
    chk("rst_valid", 64'(rpt_valid), 64'd0);
    chk("rst_index", rpt_index, 64'd0);
    chk("rst_covered", 64'(covered), 64'd0);
    chk("rst_pcnt", 64'(pending_cnt), 64'd0);
    chk("rst_allcov", 64'(all_covered), 64'd0);

    // Single rise of bit 0
    enable = 1'b1; sample = 16'h0000; step();
    sample = 16'h0001; step();
    chk("t1_covered", 64'(covered), 64'h1);
    chk("t1_pcnt", 64'(pending_cnt), 64'd1);
    chk("t1_valid_early", 64'(rpt_valid), 64'd0);
    step();
    chk("t1_valid", 64'(rpt_valid), 64'd1);
    chk("t1_index", rpt_index, CI + 0);
    rpt_ready = 1'b1; step();
    chk("t1_valid_after", 64'(rpt_valid), 64'd0);
    chk("t1_pcnt_after", 64'(pending_cnt), 64'd0);
    chk("t1_covered_after", 64'(covered), 64'h1);

    // Bit 3 toggled repeatedly: one rise and one fall only
    foreach (got_q[i]) got_q.delete();
    sample = 16'h0009; collect(1);
    sample = 16'h0001; collect(1);
    sample = 16'h0009; collect(1);
    sample = 16'h0001; collect(1);
    sample = 16'h0009; collect(1);
    sample = 16'h0001; collect(7);
    exp_q.push_back(CI + 6);
    exp_q.push_back(CI + 7);
    check_reports("t3");
    chk("t3_covered", 64'(covered), 64'hC1);

    // Full coverage: rises drain 0..30, falls start at pointer 31 then wrap
    do_reset();
    enable = 1'b1; rpt_ready = 1'b1; sample = 16'h0000; step();
    sample = 16'hFFFF; collect(20);
    sample = 16'h0000; collect(24);
    for (int i = 0; i < 16; i++) exp_q.push_back(CI + 64'(2 * i));
    exp_q.push_back(CI + 31);
    for (int i = 0; i < 15; i++) exp_q.push_back(CI + 64'(2 * i + 1));
    check_reports("t2");
    chk("t2_allcov", 64'(all_covered), 64'd1);
    chk("t2_pcnt", 64'(pending_cnt), 64'd0);
    chk("t2_covered", 64'(covered), 64'hFFFF_FFFF);

    // Backpressure: 4 pending held for 10 cycles
    do_reset();
    enable = 1'b1; sample = 16'h0000; step();
    sample = 16'h000F; step();
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rpt_valid !== 1'b1 || rpt_index !== CI) bad++;
    end
    chk("t4_stable", 64'(bad), 64'd0);
    chk("t4_valid", 64'(rpt_valid), 64'd1);
    chk("t4_index", rpt_index, CI);
    chk("t4_pcnt", 64'(pending_cnt), 64'd4);
    rpt_ready = 1'b1; collect(4);
    chk("t4_valid_after", 64'(rpt_valid), 64'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(CI + 64'(2 * i));
    check_reports("t4");
    chk("t4_pcnt_after", 64'(pending_cnt), 64'd0);

    // Clear while holding index 5 with 0, 2, 6 also pending
    do_reset();
    enable = 1'b1; sample = 16'h0004; step();
    sample = 16'h0000; step();
    step();
    sample = 16'h0003; step();
    sample = 16'h000B; step();
    chk("t5_pcnt", 64'(pending_cnt), 64'd4);
    chk("t5_index", rpt_index, CI + 5);
    chk("t5_covered", 64'(covered), 64'h65);
    clear = 1'b1; step();
    clear = 1'b0;
    chk("t5_covered_clr", 64'(covered), 64'h20);
    chk("t5_pcnt_clr", 64'(pending_cnt), 64'd1);
    chk("t5_valid_clr", 64'(rpt_valid), 64'd1);
    chk("t5_index_clr", rpt_index, CI + 5);
    rpt_ready = 1'b1; collect(5);
    exp_q.push_back(CI + 5);
    check_reports("t5a");
    sample = 16'h0000; collect(8);
    sample = 16'h000B; collect(8);
    exp_q.push_back(CI + 7);
    exp_q.push_back(CI + 1);
    exp_q.push_back(CI + 3);
    exp_q.push_back(CI + 6);
    exp_q.push_back(CI + 0);
    exp_q.push_back(CI + 2);
    check_reports("t5b");
    chk("t5_covered_end", 64'(covered), 64'hEF);

    // Re-enable primes without a false toggle
    enable = 1'b0; sample = 16'h00F0; step();
    step();
    enable = 1'b1; step();
    step();
    chk("t6_pcnt", 64'(pending_cnt), 64'd0);
    chk("t6_valid", 64'(rpt_valid), 64'd0);
    chk("t6_covered", 64'(covered), 64'hEF);

    // Async reset in the middle of HOLD
    rpt_ready = 1'b0; sample = 16'h0000; step();
    step();
    chk("t7_valid", 64'(rpt_valid), 64'd1);
    chk("t7_index", rpt_index, CI + 9);
    chk("t7_pcnt", 64'(pending_cnt), 64'd4);
    chk("t7_covered", 64'(covered), 64'hAAEF);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_valid_rst", 64'(rpt_valid), 64'd0);
    chk("t7_covered_rst", 64'(covered), 64'd0);
    chk("t7_pcnt_rst", 64'(pending_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
